mcu_arb: RTL and testbench

Parametrised memory control unit for the RV32I core: arbitrates `NPORT` requesting channels (instruction fetch, load/store, future extras) onto the single byte-wide external memory bus. Each channel issues whole 1–4 byte accesses. The arbiter serialises each access into byte cycles, reassembles little-endian read data and returns a one-cycle completion pulse. It adds round-robin arbitration, multi-byte bursts and N channels on top of the two-port address/write-enable mux it replaces, and sits between the pipeline stages and the top-level `mem_*` pins.

---
 rtl/mcu_arb.sv | 197 +++++++++++++++++++
 tb/tb_mcu_arb.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_arb.sv
// rtl/mcu_arb.sv - N-channel arbiter serialising 1-4 byte accesses onto a byte-wide memory bus
module mcu_arb #(
  parameter int NPORT     = 2,
  parameter int PRIO_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic [NPORT-1:0]    req_i,
  input  logic [NPORT-1:0]    we_i,
  input  logic [NPORT*32-1:0] addr_i,
  input  logic [NPORT*2-1:0]  len_i,
  input  logic [NPORT*32-1:0] wdata_i,
  output logic [NPORT-1:0]    gnt_o,
  output logic [NPORT-1:0]    done_o,
  output logic [31:0]         rdata_o,
  output logic                busy_o,
  input  logic [7:0]          mem_din,
  output logic [7:0]          mem_dout,
  output logic [31:0]         mem_a,
  output logic                mem_wr
);

  localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_TAIL = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ch_q, ch_d;
  logic [IW-1:0] last_q, last_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [1:0]    len_q, len_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   rbuf_q, rbuf_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          found;
  logic [IW-1:0] sel;
  int            rr_idx;

  logic          sel_we;
  logic [31:0]   sel_addr;
  logic [1:0]    sel_len;
  logic [31:0]   sel_wdata;

  // Pick the winning requester: lowest index, or first one after the last grant in round-robin mode
  always_comb begin
    found  = 1'b0;
    sel    = '0;
    rr_idx = 0;
    for (int i = 0; i < NPORT; i++) begin
      if (PRIO_MODE == 1) begin
        rr_idx = (int'(last_q) + 1 + i) % NPORT;
      end else begin
        rr_idx = i;
      end
      if (!found && req_i[rr_idx]) begin
        found = 1'b1;
        sel   = IW'(rr_idx);
      end
    end
  end

  // Extract the selected channel's request fields from the flattened input buses
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_len   = '0;
    sel_wdata = '0;
    for (int k = 0; k < NPORT; k++) begin
      if (sel == IW'(k)) begin
        sel_we    = we_i[k];
        sel_addr  = addr_i[32*k +: 32];
        sel_len   = len_i[2*k +: 2];
        sel_wdata = wdata_i[32*k +: 32];
      end
    end
  end

  // Next-state logic: grant in IDLE, one byte per XFER cycle, last read byte lands in TAIL
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_XFER;
          ch_d    = sel;
          last_d  = sel;
          we_d    = sel_we;
          addr_d  = sel_addr;
          len_d   = sel_len;
          wdata_d = sel_wdata;
          cnt_d   = 2'd0;
          rbuf_d  = '0;
        end
      end
      S_XFER: begin
        // Read data trails the address by one cycle, so byte cnt-1 is on mem_din now
        if (!we_q && (cnt_q != 2'd0)) begin
          rbuf_d[{cnt_q - 2'd1, 3'b000} +: 8] = mem_din;
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == len_q) begin
          state_d = we_q ? S_DONE : S_TAIL;
        end
      end
      S_TAIL: begin
        rbuf_d[{len_q, 3'b000} +: 8] = mem_din;
        rdata_d = rbuf_d;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers: synchronous reset wins, rdy low freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      last_q  <= IW'(NPORT - 1);
      we_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
    end
  end

  // Output decode from registered state only; mem_wr is gated by rdy so a pause never writes
  always_comb begin
    gnt_o    = '0;
    done_o   = '0;
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    busy_o   = (state_q != S_IDLE);
    if (state_q != S_IDLE) begin
      gnt_o[ch_q] = 1'b1;
    end
    if (state_q == S_DONE) begin
      done_o[ch_q] = 1'b1;
    end
    unique case (state_q)
      S_XFER: begin
        mem_a = addr_q + {30'd0, cnt_q};
        if (we_q) begin
          mem_wr   = rdy;
          mem_dout = wdata_q[{cnt_q, 3'b000} +: 8];
        end
      end
      S_TAIL: begin
        mem_a = addr_q + {30'd0, len_q};
      end
      default: begin
        mem_a = '0;
      end
    endcase
  end

  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_mcu_arb.sv
// tb/tb_mcu_arb.sv - scoreboard bench for mcu_arb (fixed-priority and round-robin instances)
module tb_mcu_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rdy;

  // fixed-priority, two channels
  logic [1:0]  req0, we0, gnt0, done0;
  logic [63:0] addr0, wdata0;
  logic [3:0]  len0;
  logic [31:0] rdata0, mem_a0;
  logic        busy0, wr0;
  logic [7:0]  din0, dout0;

  // round-robin, three channels
  logic [2:0]  req1, we1, gnt1, done1;
  logic [95:0] addr1, wdata1;
  logic [5:0]  len1;
  logic [31:0] rdata1, mem_a1;
  logic        busy1, wr1;
  logic [7:0]  din1, dout1;

  mcu_arb #(.NPORT(2), .PRIO_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .rdy(rdy),
    .req_i(req0), .we_i(we0), .addr_i(addr0), .len_i(len0), .wdata_i(wdata0),
    .gnt_o(gnt0), .done_o(done0), .rdata_o(rdata0), .busy_o(busy0),
    .mem_din(din0), .mem_dout(dout0), .mem_a(mem_a0), .mem_wr(wr0)
  );

  mcu_arb #(.NPORT(3), .PRIO_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .rdy(rdy),
    .req_i(req1), .we_i(we1), .addr_i(addr1), .len_i(len1), .wdata_i(wdata1),
    .gnt_o(gnt1), .done_o(done1), .rdata_o(rdata1), .busy_o(busy1),
    .mem_din(din1), .mem_dout(dout1), .mem_a(mem_a1), .mem_wr(wr1)
  );

  typedef struct {
    int          ch;
    logic        we;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  exp_t dq[$];
  wr_t  wq[$];
  int   rrq[$];

  logic [7:0] mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ndone0   = 0;
  int nd1      = 0;

  logic [31:0] trace[$];
  logic [1:0]  gtrace[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // one-cycle-latency byte memory for dut0, frozen while rdy is low
  always @(posedge clk) begin
    if (rdy && !rst) begin
      if (wr0) mem[mem_a0] = dout0;
      din0 <= mem.exists(mem_a0) ? mem[mem_a0] : 8'h00;
    end
  end

  exp_t em;
  wr_t  wm;

  // scoreboard pop side, sampled mid-cycle
  always @(negedge clk) begin
    if (wr0) begin
      if (wq.size() == 0) begin
        check("wr_unexpected", {31'd0, wr0}, 32'd0);
      end else begin
        wm = wq.pop_front();
        check("wr_addr", mem_a0, wm.a);
        check("wr_data", {24'd0, dout0}, {24'd0, wm.d});
      end
    end
    if (done0 != 2'b00) begin
      ndone0++;
      if (dq.size() == 0) begin
        check("done_unexpected", {30'd0, done0}, 32'd0);
      end else begin
        em = dq.pop_front();
        check("done_ch", {30'd0, done0}, 32'd1 << em.ch);
        if (!em.we) check("rdata", rdata0, em.rdata);
        if (em.cyc >= 0) check("done_cycle", cyc, em.cyc);
      end
    end
    if (done1 != 3'b000) begin
      nd1++;
      check("rr_gnt_in_done", {29'd0, gnt1}, {29'd0, done1});
      if (rrq.size() == 0) check("rr_unexpected", {29'd0, done1}, 32'd0);
      else check("rr_order", {29'd0, done1}, 32'd1 << rrq.pop_front());
    end
  end

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    mem[a]     = d;
    ref_mem[a] = d;
  endtask

  task automatic access(input int p, input logic w, input logic [31:0] a,
                        input logic [1:0] l, input logic [31:0] wd);
    int          n, c, start, lim;
    exp_t        e;
    wr_t         x;
    logic [31:0] ai;
    @(negedge clk); #1;
    n = int'(l) + 1;
    c = cyc;
    start = ndone0;
    e.ch = p;
    e.we = w;
    e.rdata = '0;
    e.cyc = c + n + (w ? 1 : 2);
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      if (w) begin
        x.a = ai;
        x.d = wd[8*i +: 8];
        wq.push_back(x);
        ref_mem[ai] = wd[8*i +: 8];
      end else begin
        e.rdata[8*i +: 8] = ref_mem.exists(ai) ? ref_mem[ai] : 8'h00;
      end
    end
    dq.push_back(e);
    req0[p] = 1'b1;
    we0[p] = w;
    addr0[32*p +: 32] = a;
    len0[2*p +: 2] = l;
    wdata0[32*p +: 32] = wd;
    trace = {};
    gtrace = {};
    lim = 0;
    while (ndone0 == start && lim < 50) begin
      @(negedge clk); #1;
      trace.push_back(mem_a0);
      gtrace.push_back(gnt0);
      lim++;
    end
    check("done_seen", ndone0 - start, 32'd1);
    check("gnt_in_done", {30'd0, gtrace[$]}, 32'd1 << p);
    req0[p] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   c, start, lim;
    exp_t e;
    wr_t  x;
    rst = 1'b1; rdy = 1'b1;
    req0 = '0; we0 = '0; addr0 = '0; len0 = '0; wdata0 = '0;
    req1 = '0; we1 = '0; addr1 = '0; len1 = '0; wdata1 = '0; din1 = 8'h00;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk); #1;
    check("rst_gnt0", {30'd0, gnt0}, 32'd0);
    check("rst_done0", {30'd0, done0}, 32'd0);
    check("rst_busy0", {31'd0, busy0}, 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_mem_a0", mem_a0, 32'd0);
    check("rst_wr0", {31'd0, wr0}, 32'd0);
    check("rst_dout0", {24'd0, dout0}, 32'd0);
    check("rst_busy1", {31'd0, busy1}, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_idle1", {mem_a1[29:0], wr1, |dout1}, 32'd0);

    // 4-byte write, port 0
    access(0, 1'b1, 32'h0000_0100, 2'd3, 32'hDEAD_BEEF);
    check("wr_gnt_first", {30'd0, gtrace[0]}, 32'd1);
    @(negedge clk); #1;
    check("idle_gnt", {30'd0, gnt0}, 32'd0);
    check("idle_mem_a", mem_a0, 32'd0);

    // 2-byte read, port 1
    preload(32'h200, 8'h34);
    preload(32'h201, 8'h12);
    access(1, 1'b0, 32'h0000_0200, 2'd1, 32'd0);
    check("rd_gnt_first", {30'd0, gtrace[0]}, 32'd2);
    check("rd_a0", trace[0], 32'h200);
    check("rd_a1", trace[1], 32'h201);
    check("rd_value", rdata0, 32'h0000_1234);

    // writes leave rdata_o alone
    access(0, 1'b1, 32'h0000_0104, 2'd1, 32'h0000_BEEF);
    @(negedge clk); #1;
    check("rdata_hold", rdata0, 32'h0000_1234);

    access(0, 1'b0, 32'h0000_0100, 2'd3, 32'd0);
    access(1, 1'b0, 32'h0000_0102, 2'd0, 32'd0);
    access(0, 1'b0, 32'h0000_0104, 2'd2, 32'd0);

    // address wrap across 0xFFFFFFFF
    preload(32'hFFFF_FFFE, 8'h11);
    preload(32'hFFFF_FFFF, 8'h22);
    preload(32'h0000_0000, 8'h33);
    preload(32'h0000_0001, 8'h44);
    access(0, 1'b0, 32'hFFFF_FFFE, 2'd3, 32'd0);
    check("wrap_a0", trace[0], 32'hFFFF_FFFE);
    check("wrap_a1", trace[1], 32'hFFFF_FFFF);
    check("wrap_a2", trace[2], 32'h0000_0000);
    check("wrap_a3", trace[3], 32'h0000_0001);
    check("wrap_rdata", rdata0, 32'h4433_2211);

    // three-cycle pause in the middle of a write
    @(negedge clk); #1;
    c = cyc;
    start = ndone0;
    for (int i = 0; i < 4; i++) begin
      x.a = 32'h300 + 32'(i);
      x.d = 8'(32'hCAFE_F00D >> (8 * i));
      wq.push_back(x);
      ref_mem[x.a] = x.d;
    end
    e.ch = 0; e.we = 1'b1; e.rdata = '0; e.cyc = c + 8;
    dq.push_back(e);
    req0[0] = 1'b1; we0[0] = 1'b1; addr0[31:0] = 32'h300; len0[1:0] = 2'd3;
    wdata0[31:0] = 32'hCAFE_F00D;
    @(negedge clk);
    @(posedge clk); #2 rdy = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      check("pause_mem_a", mem_a0, 32'h301);
      check("pause_wr", {31'd0, wr0}, 32'd0);
    end
    @(posedge clk); #2 rdy = 1'b1;
    lim = 0;
    while (ndone0 == start && lim < 40) begin
      @(negedge clk); #1;
      lim++;
    end
    check("pause_done_seen", ndone0 - start, 32'd1);
    req0[0] = 1'b0;
    access(1, 1'b0, 32'h0000_0300, 2'd3, 32'd0);

    // fixed priority: port 0 keeps winning until it lets go
    preload(32'h500, 8'hA5);
    preload(32'h600, 8'h5A);
    @(negedge clk); #1;
    @(negedge clk); #1;
    c = cyc;
    start = ndone0;
    for (int i = 0; i < 3; i++) begin
      e.ch = 0; e.we = 1'b0; e.rdata = 32'hA5; e.cyc = c + 3 + 4 * i;
      dq.push_back(e);
    end
    e.ch = 1; e.we = 1'b0; e.rdata = 32'h5A; e.cyc = c + 15;
    dq.push_back(e);
    we0 = 2'b00; len0 = 4'd0; addr0 = {32'h600, 32'h500};
    req0 = 2'b11;
    lim = 0;
    while (ndone0 < start + 3 && lim < 100) begin
      @(negedge clk); #1;
      lim++;
    end
    req0[0] = 1'b0;
    while (ndone0 < start + 4 && lim < 100) begin
      @(negedge clk); #1;
      lim++;
    end
    req0[1] = 1'b0;
    check("prio_count", ndone0 - start, 32'd4);

    // round-robin across three channels
    @(negedge clk); #1;
    start = nd1;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) rrq.push_back(i);
    end
    req1 = 3'b111;
    lim = 0;
    while (nd1 < start + 6 && lim < 100) begin
      @(negedge clk); #1;
      lim++;
    end
    req1 = 3'b000;
    check("rr_count", nd1 - start, 32'd6);

    // reset in the second cycle of a write aborts it silently
    @(negedge clk); #1;
    @(negedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      x.a = 32'h400 + 32'(i);
      x.d = 8'(32'h8765_4321 >> (8 * i));
      wq.push_back(x);
    end
    req0[0] = 1'b1; we0[0] = 1'b1; addr0[31:0] = 32'h400; len0[1:0] = 2'd3;
    wdata0[31:0] = 32'h8765_4321;
    @(posedge clk);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    req0[0] = 1'b0;
    @(negedge clk); #1;
    check("abort_gnt", {30'd0, gnt0}, 32'd0);
    check("abort_done", {30'd0, done0}, 32'd0);
    check("abort_busy", {31'd0, busy0}, 32'd0);
    check("abort_rdata", rdata0, 32'd0);
    check("abort_mem_a", mem_a0, 32'd0);
    check("abort_wr", {31'd0, wr0}, 32'd0);
    check("abort_dout", {24'd0, dout0}, 32'd0);
    repeat (8) @(negedge clk);
    #1;
    check("dq_empty", dq.size(), 32'd0);
    check("wq_empty", wq.size(), 32'd0);
    check("rrq_empty", rrq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
